// File: rtl/rd53_cmd_pkg.sv
// rd53_cmd_pkg: RD53A command symbols, fixed frames and encoder state type.
package rd53_cmd_pkg;
  localparam logic [15:0] SYNC_C = 16'h817E;
  localparam logic [15:0] NOOP_C = 16'h6969;
  localparam logic [7:0] TRIG_SYM [16] = '{
    8'h00, 8'h2B, 8'h2D, 8'h2E, 8'h33, 8'h35, 8'h36, 8'h39,
    8'h3A, 8'h3C, 8'h4B, 8'h4D, 8'h4E, 8'h53, 8'h55, 8'h56};
  localparam logic [7:0] DATA_SYM [32] = '{
    8'h6A, 8'h6C, 8'h71, 8'h72, 8'h74, 8'h8B, 8'h8D, 8'h8E,
    8'h93, 8'h95, 8'h96, 8'h99, 8'h9A, 8'h9C, 8'hA3, 8'hA5,
    8'hA6, 8'hA9, 8'hAA, 8'hAC, 8'hB1, 8'hB2, 8'hB4, 8'hC3,
    8'hC5, 8'hC6, 8'hC9, 8'hCA, 8'hCC, 8'hD1, 8'hD2, 8'hD4};
  typedef enum logic {STARTUP, RUN} state_e;
  function automatic logic [15:0] trig_frame(input logic [3:0] pattern, input logic [4:0] tag);
    return {TRIG_SYM[pattern], DATA_SYM[tag]};
  endfunction
endpackage

// File: rtl/rd53_cmd_shifter.sv
// rd53_cmd_shifter: 16-bit parallel-in/serial-out, MSB first, with load point marker.
module rd53_cmd_shifter (
  input  logic        clk160MHz,
  input  logic        rstL,
  input  logic [15:0] frame_i,
  output logic        load_req_o,
  output logic        ser_o,
  output logic        frame_start_o
);
  // Bit 15 goes straight to ser_o at load, so only the low 15 bits are held.
  logic [14:0] sh_q;
  logic [3:0]  cnt_q;
  logic        first_q;
  assign load_req_o = first_q | (cnt_q == 4'd15);
  always_ff @(posedge clk160MHz) begin
    if (!rstL) begin
      sh_q          <= '0;
      cnt_q         <= '0;
      first_q       <= 1'b1;
      ser_o         <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (load_req_o) begin
      sh_q          <= frame_i[14:0];
      cnt_q         <= '0;
      first_q       <= 1'b0;
      ser_o         <= frame_i[15];
      frame_start_o <= 1'b1;
    end else begin
      sh_q          <= {sh_q[13:0], 1'b0};
      cnt_q         <= cnt_q + 4'd1;
      ser_o         <= sh_q[14];
      frame_start_o <= 1'b0;
    end
  end
endmodule

// File: rtl/rd53_cmd_encoder.sv
// rd53_cmd_encoder: RD53A command stream builder with startup/periodic sync insertion.
module rd53_cmd_encoder
  import rd53_cmd_pkg::*;
#(
  parameter int SYNC_STARTUP_G = 32,
  parameter int SYNC_PERIOD_G  = 32
) (
  input  logic        clk160MHz,
  input  logic        rstL,
  input  logic        cmdValid,
  input  logic [15:0] cmdData,
  output logic        cmdReady,
  input  logic        trigValid,
  input  logic [3:0]  trigPattern,
  input  logic [4:0]  trigTag,
  output logic        trigReady,
  output logic        trigErr,
  output logic        serOut,
  output logic        frameStart,
  output logic        syncBusy
);
  state_e      state_q;
  logic [7:0]  start_q, start_d, since_q;
  logic        busy_q, load_req, load, sync_due;
  logic [15:0] frame;
  // Handshakes are combinational in the load cycle; the frame is taken at its closing edge.
  always_comb begin
    load      = load_req & rstL;
    sync_due  = (state_q != RUN) || (since_q == 8'(SYNC_PERIOD_G - 1));
    trigReady = load & ~sync_due & trigValid;
    trigErr   = trigReady & (trigPattern == 4'd0);
    cmdReady  = load & ~sync_due & ~trigValid & cmdValid;
    start_d   = start_q + 8'd1;
    frame     = sync_due  ? SYNC_C :
                trigValid ? ((trigPattern == 4'd0) ? NOOP_C : trig_frame(trigPattern, trigTag)) :
                cmdValid  ? cmdData : NOOP_C;
  end
  assign syncBusy = busy_q;
  always_ff @(posedge clk160MHz) begin
    if (!rstL) begin
      state_q <= STARTUP;
      start_q <= '0;
      since_q <= '0;
      busy_q  <= 1'b1;
    end else if (load) begin
      since_q <= sync_due ? 8'd0 : since_q + 8'd1;
      if (state_q == STARTUP) begin
        start_q <= start_d;
        if (start_d == 8'(SYNC_STARTUP_G)) begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      end
    end
  end
  rd53_cmd_shifter u_shift (
    .clk160MHz     (clk160MHz),
    .rstL          (rstL),
    .frame_i       (frame),
    .load_req_o    (load_req),
    .ser_o         (serOut),
    .frame_start_o (frameStart)
  );
endmodule

// File: tb/tb_rd53_cmd_encoder.sv
// tb_rd53_cmd_encoder: directed vector bench for the RD53A command encoder.
module tb_rd53_cmd_encoder;
  localparam logic [15:0] SYNC = 16'h817E;
  localparam logic [15:0] NOOP = 16'h6969;
  logic        clk = 1'b0;
  logic        rstL = 1'b0;
  logic        cmdValid = 1'b0, trigValid = 1'b0;
  logic [15:0] cmdData = '0;
  logic [3:0]  trigPattern = '0;
  logic [4:0]  trigTag = '0;
  logic        cmdReady, trigReady, trigErr, serOut, frameStart, syncBusy;
  int          checks = 0, errors = 0, since_m = 0;
  int          cmd_cnt = 0, trig_cnt = 0, err_cnt = 0;
  typedef struct {
    logic tv; logic [3:0] p; logic [4:0] t; logic cv; logic [15:0] cd;
    logic [15:0] ef; logic etr; logic eer; logic ecr;
  } vec_t;
  vec_t vecs[10];

  rd53_cmd_encoder dut (
    .clk160MHz(clk), .rstL(rstL), .cmdValid(cmdValid), .cmdData(cmdData), .cmdReady(cmdReady),
    .trigValid(trigValid), .trigPattern(trigPattern), .trigTag(trigTag), .trigReady(trigReady),
    .trigErr(trigErr), .serOut(serOut), .frameStart(frameStart), .syncBusy(syncBusy)
  );

  always #3 clk = ~clk;

  always @(negedge clk) begin
    #1;
    if (rstL) begin
      cmd_cnt  += int'(cmdReady);
      trig_cnt += int'(trigReady);
      err_cnt  += int'(trigErr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Returns at the negedge of the frame's last bit, which is the next load cycle.
  task automatic next_frame(output logic [15:0] f, output logic busy, output int waited);
    f = '0; busy = 1'b0; waited = 0;
    do begin @(negedge clk); waited++; end while (!frameStart && waited < 40);
    if (!frameStart) begin
      checks++; errors++;
      $display("FAIL frame_timeout got=none want=frameStart");
    end
    busy = syncBusy;
    f[15] = serOut;
    for (int i = 14; i >= 0; i--) begin @(negedge clk); f[i] = serOut; end
  endtask

  task automatic step(input vec_t v);
    logic [15:0] f; logic b; int w; logic tr, er, cr;
    if (since_m == 31) begin
      #1;
      check("sync_no_ready", {30'd0, trigReady, cmdReady}, 32'd0);
      next_frame(f, b, w);
      check("sync_inserted", {16'd0, f}, {16'd0, SYNC});
      since_m = 0;
    end
    trigValid = v.tv; trigPattern = v.p; trigTag = v.t; cmdValid = v.cv; cmdData = v.cd;
    #1;
    tr = trigReady; er = trigErr; cr = cmdReady;
    check("vec_trig_ready", {31'd0, tr}, {31'd0, v.etr});
    check("vec_trig_err", {31'd0, er}, {31'd0, v.eer});
    check("vec_cmd_ready", {31'd0, cr}, {31'd0, v.ecr});
    @(posedge clk); #1;
    if (tr) trigValid = 1'b0;
    if (cr) cmdValid = 1'b0;
    next_frame(f, b, w);
    check("vec_frame", {16'd0, f}, {16'd0, v.ef});
    since_m++;
  endtask

  initial begin
    logic [15:0] f; logic b; int w, c0, exp_cmd;
    vecs[0] = '{1'b1, 4'd1,  5'd0,  1'b0, 16'h0000, 16'h2B6A, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'd15, 5'd31, 1'b0, 16'h0000, 16'h56D4, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'd5,  5'd10, 1'b0, 16'h0000, 16'h3596, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 4'd10, 5'd23, 1'b0, 16'h0000, 16'h4BC3, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'd0,  5'd3,  1'b0, 16'h0000, NOOP,     1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'd0,  5'd0,  1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 4'd8,  5'd16, 1'b1, 16'hBEEF, 16'h3AA6, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 4'd0,  5'd0,  1'b1, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 4'd0,  5'd0,  1'b0, 16'h0000, NOOP,     1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 4'd2,  5'd5,  1'b0, 16'h0000, 16'h2D8B, 1'b1, 1'b0, 1'b0};

    // Reset with requests already pending; they must be ignored through startup.
    cmdValid = 1'b1; cmdData = 16'h1111; trigValid = 1'b1; trigPattern = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ser", {31'd0, serOut}, 32'd0);
    check("rst_fs", {31'd0, frameStart}, 32'd0);
    check("rst_busy", {31'd0, syncBusy}, 32'd1);
    check("rst_ready", {29'd0, cmdReady, trigReady, trigErr}, 32'd0);
    @(negedge clk); rstL = 1'b1;
    for (int i = 0; i < 32; i++) begin
      next_frame(f, b, w);
      check("startup_sync", {16'd0, f}, {16'd0, SYNC});
      if (i < 31) check("startup_busy", {31'd0, b}, 32'd1);
      if (i == 30) begin cmdValid = 1'b0; trigValid = 1'b0; end
    end
    check("startup_no_ready", cmd_cnt + trig_cnt + err_cnt, 32'd0);
    since_m = 0;
    for (int i = 0; i < 3; i++) begin
      next_frame(f, b, w);
      check("idle_noop", {16'd0, f}, {16'd0, NOOP});
      check("idle_busy", {31'd0, b}, 32'd0);
      check("idle_period", w, 32'd1);
      since_m++;
    end

    // Continuous command stream with periodic sync.
    c0 = cmd_cnt; exp_cmd = 0;
    cmdValid = 1'b1; cmdData = 16'hA5C3;
    for (int i = 0; i < 64; i++) begin
      next_frame(f, b, w);
      check("stream_frame", {16'd0, f}, (since_m == 31) ? {16'd0, SYNC} : 32'h0000A5C3);
      exp_cmd += (since_m == 31) ? 0 : 1;
      since_m = (since_m == 31) ? 0 : since_m + 1;
    end
    cmdValid = 1'b0;
    check("stream_cmd_ready_count", cmd_cnt - c0, exp_cmd);

    for (int i = 0; i < 10; i++) step(vecs[i]);

    // Reset mid-frame at bit 7 with a command pending.
    w = 0;
    do begin @(negedge clk); w++; end while (!frameStart && w < 40);
    check("mid_frame_found", {31'd0, frameStart}, 32'd1);
    repeat (7) @(negedge clk);
    rstL = 1'b0; cmdValid = 1'b1; cmdData = 16'hCAFE;
    @(posedge clk); #1;
    check("midrst_ser", {31'd0, serOut}, 32'd0);
    check("midrst_busy", {31'd0, syncBusy}, 32'd1);
    check("midrst_fs", {31'd0, frameStart}, 32'd0);
    @(negedge clk); rstL = 1'b1;
    c0 = cmd_cnt;
    for (int i = 0; i < 32; i++) begin
      next_frame(f, b, w);
      check("restart_sync", {16'd0, f}, {16'd0, SYNC});
    end
    check("restart_no_cmd", cmd_cnt - c0, 32'd0);
    next_frame(f, b, w);
    cmdValid = 1'b0;
    check("restart_cmd_frame", {16'd0, f}, 32'h0000CAFE);
    check("restart_cmd_ready", cmd_cnt - c0, 32'd1);
    check("restart_busy", {31'd0, b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
